fetch_sequencer: RTL

- Controller that sequences instruction fetch for the single-cycle MIPS core.
- Owns the 13-bit word-addressed PC and issues read requests to the instruction memory with a req/valid handshake.
- Presents each fetched instruction to the decode stage, applies branch/jump redirects, and detects end of program against a loaded program size.
- Replaces free-running PC/adder chaining with an explicit state machine and a proper reset.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_next_pc.sv | 28 ++
 rtl/fetch_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Holds the FSM state encoding and default widths/reset PC.
package fetch_pkg;

  localparam int DEF_ADDR_W   = 13;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_RESET_PC = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC select (halt > redirect > increment) and end-of-program test.
// The compare is one bit wider than the PC so pc=max+1 never wraps to 0.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              halt_req,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [ADDR_W:0]   size,
  output logic [ADDR_W-1:0] next_pc,
  output logic              done
);

  logic [ADDR_W:0] target;

  always_comb begin
    target = {1'b0, pc} + 1'b1;
    if (redirect_valid) begin
      target = {1'b0, redirect_pc};
    end
    next_pc = target[ADDR_W-1:0];
    done    = halt_req || (target >= size);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch FSM: IDLE -> WAIT -> ISSUE -> ... -> DONE.
// Define FETCH_RETIRE_COUNT_EN to add the retired_count output.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   prog_size,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic              end_program,
  output logic [1:0]        state
`ifdef FETCH_RETIRE_COUNT_EN
  ,
  output logic [31:0]       retired_count
`endif
);

  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  fetch_state_t      st, st_n;
  logic [ADDR_W:0]   size, size_n;
  logic [ADDR_W-1:0] pc_n, next_pc;
  logic [DATA_W-1:0] instr_n;
  logic              req_n, valid_n, end_n;
  logic              accept, done;

  fetch_next_pc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc             (pc),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .size           (size),
    .next_pc        (next_pc),
    .done           (done)
  );

  assign imem_addr = pc;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      pc          <= PC0;
      size        <= '0;
      imem_req    <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      end_program <= 1'b0;
    end else begin
      st          <= st_n;
      pc          <= pc_n;
      size        <= size_n;
      imem_req    <= req_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      end_program <= end_n;
    end
  end

  always_comb begin
    st_n    = st;
    pc_n    = pc;
    size_n  = size;
    req_n   = imem_req;
    instr_n = instr;
    valid_n = instr_valid;
    end_n   = end_program;
    accept  = 1'b0;
    unique case (st)
      S_IDLE: begin
        if (start) begin
          if (prog_size == '0) begin
            st_n  = S_DONE;
            end_n = 1'b1;
          end else begin
            size_n = prog_size;
            req_n  = 1'b1;
            st_n   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (imem_valid) begin
          instr_n = imem_rdata;
          valid_n = 1'b1;
          req_n   = 1'b0;
          st_n    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          accept  = 1'b1;
          valid_n = 1'b0;
          if (done) begin
            end_n = 1'b1;
            st_n  = S_DONE;
          end else begin
            pc_n  = next_pc;
            req_n = 1'b1;
            st_n  = S_WAIT;
          end
        end
      end
      S_DONE: begin
        end_n   = 1'b1;
        req_n   = 1'b0;
        valid_n = 1'b0;
      end
      default: st_n = S_IDLE;
    endcase
  end

`ifdef FETCH_RETIRE_COUNT_EN
  // Saturating count of instructions accepted by decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_count <= '0;
    end else if (accept && retired_count != 32'hFFFF_FFFF) begin
      retired_count <= retired_count + 32'd1;
    end
  end
`endif

endmodule
